// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 Hz VGA raster timing constants and coordinate type.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Inclusive bounds of the sync pulse, in counter units.
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with carry and registered sync/visible decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL,
  parameter int VISIBLE    = H_VISIBLE,
  parameter int SYNC_START = H_SYNC_START,
  parameter int SYNC_END   = H_SYNC_END
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       en,
  output logic [9:0] count,
  output logic       carry,
  output logic       sync_n,
  output logic       visible
);

  coord_t count_next;

  assign carry = en && (count == coord_t'(TOTAL - 1));

  always_comb begin
    count_next = count;
    if (carry)
      count_next = '0;
    else if (en)
      count_next = count + coord_t'(1);
  end

  // Strobes decode the next count so they land on the same edge as the coordinate.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count   <= '0;
      sync_n  <= 1'b1;
      visible <= 1'b1;
    end else begin
      count   <= count_next;
      sync_n  <= !((count_next >= coord_t'(SYNC_START)) && (count_next <= coord_t'(SYNC_END)));
      visible <= (count_next < coord_t'(VISIBLE));
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA raster generator on the 50 MHz clock with a /2 pixel enable.
// Optional VGA_FRAME_TICK_EN adds frame_tick, a one-Clk pulse at the start of vertical blank.
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS = H_VISIBLE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_VIS = V_VISIBLE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC,
  parameter int V_BP  = V_BACK
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_Clk,
  output logic       frame_clk
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);

  localparam int HT = H_VIS + H_FP + H_SW + H_BP;
  localparam int VT = V_VIS + V_FP + V_SW + V_BP;

  logic pix_tgl;
  logic pix_en;
  logic h_carry;
  logic v_carry_unused;
  logic h_sync_n, v_sync_n;
  logic h_vis, v_vis;

  always_ff @(posedge Clk) begin
    if (Reset)
      pix_tgl <= 1'b0;
    else
      pix_tgl <= ~pix_tgl;
  end

  assign pix_en = pix_tgl;

  vga_axis_counter #(
    .TOTAL      (HT),
    .VISIBLE    (H_VIS),
    .SYNC_START (H_VIS + H_FP),
    .SYNC_END   (H_VIS + H_FP + H_SW - 1)
  ) u_h (
    .Clk     (Clk),
    .Reset   (Reset),
    .en      (pix_en),
    .count   (DrawX),
    .carry   (h_carry),
    .sync_n  (h_sync_n),
    .visible (h_vis)
  );

  vga_axis_counter #(
    .TOTAL      (VT),
    .VISIBLE    (V_VIS),
    .SYNC_START (V_VIS + V_FP),
    .SYNC_END   (V_VIS + V_FP + V_SW - 1)
  ) u_v (
    .Clk     (Clk),
    .Reset   (Reset),
    .en      (h_carry),
    .count   (DrawY),
    .carry   (v_carry_unused),
    .sync_n  (v_sync_n),
    .visible (v_vis)
  );

  assign VGA_HS      = h_sync_n;
  assign VGA_VS      = v_sync_n;
  assign VGA_BLANK_N = h_vis & v_vis;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_Clk     = pix_tgl;
  assign frame_clk   = v_sync_n;

`ifdef VGA_FRAME_TICK_EN
  // The line ending on the last visible row moves DrawY into the first blank row.
  always_ff @(posedge Clk) begin
    if (Reset)
      frame_tick <= 1'b0;
    else
      frame_tick <= h_carry && (DrawY == coord_t'(V_VIS - 1));
  end
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - scoreboard bench: full-size and shrunken-timing instances against a pixel-count model.
module tb_vga_scan_gen;

  typedef struct {
    int x;
    int y;
    int hs;
    int vs;
    int blank;
    int vclk;
    int tick;
  } exp_t;

  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VV = 6, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_FRAME_CLK = 2 * (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);

  logic Clk = 1'b0;
  logic Reset;

  logic [9:0] f_x, f_y, s_x, s_y;
  logic f_hs, f_vs, f_blank, f_sync, f_vclk, f_fclk;
  logic s_hs, s_vs, s_blank, s_sync, s_vclk, s_fclk;
`ifdef VGA_FRAME_TICK_EN
  logic f_tick, s_tick;
`endif

  int errors = 0;
  int checks = 0;
  int k = 0;
  exp_t q_full[$];
  exp_t q_small[$];

  always #10 Clk = ~Clk;

  vga_scan_gen dut_full (
    .Clk(Clk), .Reset(Reset), .DrawX(f_x), .DrawY(f_y),
    .VGA_HS(f_hs), .VGA_VS(f_vs), .VGA_BLANK_N(f_blank), .VGA_SYNC_N(f_sync),
    .VGA_Clk(f_vclk), .frame_clk(f_fclk)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(f_tick)
`endif
  );

  vga_scan_gen #(
    .H_VIS(S_HV), .H_FP(S_HF), .H_SW(S_HS), .H_BP(S_HB),
    .V_VIS(S_VV), .V_FP(S_VF), .V_SW(S_VS), .V_BP(S_VB)
  ) dut_small (
    .Clk(Clk), .Reset(Reset), .DrawX(s_x), .DrawY(s_y),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_blank), .VGA_SYNC_N(s_sync),
    .VGA_Clk(s_vclk), .frame_clk(s_fclk)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(s_tick)
`endif
  );

  // k counts Clk edges since reset released; every second edge is one pixel.
  function automatic exp_t model(int kk, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb);
    exp_t e;
    int ht, vt, p;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p = kk / 2;
    e.x = p % ht;
    e.y = (p / ht) % vt;
    e.hs = (e.x >= hv + hf && e.x < hv + hf + hsw) ? 0 : 1;
    e.vs = (e.y >= vv + vf && e.y < vv + vf + vsw) ? 0 : 1;
    e.blank = (e.x < hv && e.y < vv) ? 1 : 0;
    e.vclk = kk % 2;
    e.tick = (kk > 0 && kk % 2 == 0 && e.x == 0 && e.y == vv) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r);
    Reset = r;
    @(posedge Clk);
    #1;
    if (r) k = 0;
    else k++;
    q_full.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33));
    q_small.push_back(model(k, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB));
  endtask

  // Monitor: compares whatever the driver has queued at each falling edge.
  int cyc = 0;
  int last_rise = -1;
  logic prev_fclk = 1'b1;
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      cyc++;
      if (q_full.size() != 0) begin
        e = q_full.pop_front();
        chk("full_x", int'(f_x), e.x);
        chk("full_y", int'(f_y), e.y);
        chk("full_hs", int'(f_hs), e.hs);
        chk("full_vs", int'(f_vs), e.vs);
        chk("full_blank", int'(f_blank), e.blank);
        chk("full_vclk", int'(f_vclk), e.vclk);
        chk("full_fclk", int'(f_fclk), e.vs);
        chk("full_sync_n", int'(f_sync), 0);
`ifdef VGA_FRAME_TICK_EN
        chk("full_tick", int'(f_tick), e.tick);
`endif
      end
      if (q_small.size() != 0) begin
        e = q_small.pop_front();
        chk("small_x", int'(s_x), e.x);
        chk("small_y", int'(s_y), e.y);
        chk("small_hs", int'(s_hs), e.hs);
        chk("small_vs", int'(s_vs), e.vs);
        chk("small_blank", int'(s_blank), e.blank);
        chk("small_vclk", int'(s_vclk), e.vclk);
        chk("small_fclk", int'(s_fclk), e.vs);
        chk("small_sync_n", int'(s_sync), 0);
        chk("small_blank_in_sync", int'(s_blank && !(s_hs && s_vs)), 0);
`ifdef VGA_FRAME_TICK_EN
        chk("small_tick", int'(s_tick), e.tick);
`endif
      end
      chk("full_blank_in_sync", int'(f_blank && !(f_hs && f_vs)), 0);
      if (Reset)
        last_rise = -1;
      else if (!prev_fclk && s_fclk) begin
        if (last_rise >= 0)
          chk("small_frame_period", cyc - last_rise, S_FRAME_CLK);
        last_rise = cyc;
      end
      prev_fclk = s_fclk;
    end
  end

  initial begin
    int n;
    repeat (3) step(1'b1);
    n = $urandom_range(2000, 5000);
    repeat (n) step(1'b0);
    n = $urandom_range(1, 3);
    repeat (n) step(1'b1);
    n = $urandom_range(3000, 4000);
    repeat (n) step(1'b0);
    repeat (3) @(posedge Clk);
    #1;
    chk("queues_drained", q_full.size() + q_small.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
